// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   - RV64I load/store funct3 encodings
//   - access FSM state type
//   - byte-enable mask helper for store lanes
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  // Byte enables for an access of size funct3[1:0] starting at byte lane off.
  function automatic logic [7:0] be_mask(input logic [2:0] funct3, input logic [2:0] off);
    logic [7:0] mask;
    unique case (funct3[1:0])
      2'b00:   mask = 8'h01 << off;
      2'b01:   mask = 8'h03 << off;
      2'b10:   mask = 8'h0F << off;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data aligner: selects the addressed lane of a raw 64-bit doubleword and
// sign- or zero-extends it according to the RV64I load funct3.
//   rdata_i          raw doubleword from the data-memory bus
//   off_i            byte offset within the doubleword (addr[2:0])
//   funct3_i         load size / signedness
//   read_data_next_o aligned, extended load value
module load_align_ext
  import mem_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] read_data_next_o
);

  logic [63:0] shifted;
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    read_data_next_o = '0;
    unique case (funct3_i)
      F3_B:    read_data_next_o = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    read_data_next_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    read_data_next_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    read_data_next_o = shifted;
      F3_BU:   read_data_next_o = {56'd0, shifted[7:0]};
      F3_HU:   read_data_next_o = {48'd0, shifted[15:0]};
      F3_WU:   read_data_next_o = {32'd0, shifted[31:0]};
      default: read_data_next_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit. Turns EX/MEM load/store controls into a
// req/gnt/rvalid bus transaction, aligns load data into ReadData, stalls the
// pipeline while the access is outstanding and flags illegal, misaligned or
// timed-out accesses.
//   clk, reset                  clock, async active-high reset
//   EXM_*                       load/store controls, address and store data
//   ReadData                    aligned load result for MEM/WB
//   mem_stall, mem_fault        pipeline freeze / access fault
//   dmem_*                      data-memory bus
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXM_MemRead,
  input  logic              EXM_MemWrite,
  input  logic [2:0]        EXM_funct3,
  input  logic [XLEN-1:0]   EXM_ALUResult,
  input  logic [XLEN-1:0]   EXM_WriteData,
  output logic [XLEN-1:0]   ReadData,
  output logic              mem_stall,
  output logic              mem_fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        off_q, off_d;

  logic              op, illegal, misaligned;
  logic [2:0]        off;
  logic [XLEN-1:0]   ld_data;

  // Only the bus-address bits are captured; the rest of the address is dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^EXM_ALUResult[XLEN-1:ADDR_W];

  assign op  = EXM_MemRead | EXM_MemWrite;
  assign off = EXM_ALUResult[2:0];

  always_comb begin
    misaligned = 1'b0;
    unique case (EXM_funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = |off[1:0];
      2'b11:   misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal = (EXM_MemRead & EXM_MemWrite)
                 | (EXM_MemRead & (EXM_funct3 == 3'b111))
                 | (EXM_MemWrite & EXM_funct3[2])
                 | misaligned;

  load_align_ext u_load_align_ext (
    .rdata_i          (dmem_rdata),
    .off_i            (off_q),
    .funct3_i         (f3_q),
    .read_data_next_o (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    off_d     = off_q;
    mem_stall = 1'b0;
    mem_fault = 1'b0;
    dmem_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op) begin
          if (illegal) begin
            mem_fault = 1'b1;
          end else begin
            mem_stall = 1'b1;
            addr_d    = {EXM_ALUResult[ADDR_W-1:3], 3'b000};
            we_d      = EXM_MemWrite;
            be_d      = be_mask(EXM_funct3, off);
            wdata_d   = EXM_WriteData << {off, 3'b000};
            f3_d      = EXM_funct3;
            off_d     = off;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        // rvalid takes priority over a coincident timeout.
        if (dmem_rvalid) begin
          rd_d    = ld_data;
          state_d = DONE;
        end else if (cnt_d == TimeoutCnt) begin
          rd_d    = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        mem_fault = fault_q;
        cnt_d     = '0;
        fault_d   = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign ReadData   = rd_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT = 4).
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        EXM_MemRead;
  logic        EXM_MemWrite;
  logic [2:0]  EXM_funct3;
  logic [63:0] EXM_ALUResult;
  logic [63:0] EXM_WriteData;
  logic [63:0] ReadData;
  logic        mem_stall;
  logic        mem_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int checks;
  int failures;
  int stall_cnt;

  mem_access_stage #(
    .XLEN    (64),
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .EXM_MemRead   (EXM_MemRead),
    .EXM_MemWrite  (EXM_MemWrite),
    .EXM_funct3    (EXM_funct3),
    .EXM_ALUResult (EXM_ALUResult),
    .EXM_WriteData (EXM_WriteData),
    .ReadData      (ReadData),
    .mem_stall     (mem_stall),
    .mem_fault     (mem_fault),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Load: gnt in first REQ cycle, rvalid in first WAIT cycle; returns in DONE.
  task automatic load_txn(input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata);
    cyc();
    EXM_MemRead = 1'b1; EXM_funct3 = f3; EXM_ALUResult = addr;
    #1;
    chk("ld_idle_stall", 64'(mem_stall), 64'd1);
    cyc();
    dmem_gnt = 1'b1;
    #1;
    chk("ld_req", 64'(dmem_req), 64'd1);
    cyc();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    cyc();
    dmem_rvalid = 1'b0; EXM_MemRead = 1'b0;
    #1;
    chk("ld_done_state", 64'(dut.state_q), 64'(DONE));
    chk("ld_done_fault", 64'(mem_fault), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0; stall_cnt = 0;
    reset = 1'b1;
    EXM_MemRead = 1'b0; EXM_MemWrite = 1'b0; EXM_funct3 = 3'b000;
    EXM_ALUResult = '0; EXM_WriteData = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

    // Reset state
    #2;
    chk("rst_readdata", ReadData, 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_be", 64'(dmem_be), 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_fault", 64'(mem_fault), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // ld 0x1000: REQ two cycles (gnt in second), WAIT two cycles (rvalid in second)
    cyc();
    EXM_MemRead = 1'b1; EXM_funct3 = F3_D; EXM_ALUResult = 64'h1000;
    #1; stall_cnt += int'(mem_stall);
    chk("ld_idle_req", 64'(dmem_req), 64'd0);
    cyc(); #1; stall_cnt += int'(mem_stall);
    chk("ld_req1", 64'(dmem_req), 64'd1);
    chk("ld_addr", 64'(dmem_addr), 64'h1000);
    chk("ld_be", 64'(dmem_be), 64'hFF);
    chk("ld_we", 64'(dmem_we), 64'd0);
    cyc(); dmem_gnt = 1'b1; #1; stall_cnt += int'(mem_stall);
    chk("ld_req2", 64'(dmem_req), 64'd1);
    cyc(); dmem_gnt = 1'b0; #1; stall_cnt += int'(mem_stall);
    chk("ld_wait_req", 64'(dmem_req), 64'd0);
    cyc(); dmem_rvalid = 1'b1; dmem_rdata = 64'h1122334455667788; #1;
    stall_cnt += int'(mem_stall);
    cyc(); dmem_rvalid = 1'b0; EXM_MemRead = 1'b0; #1; stall_cnt += int'(mem_stall);
    chk("ld_done_state", 64'(dut.state_q), 64'(DONE));
    chk("ld_readdata", ReadData, 64'h1122334455667788);
    chk("ld_fault", 64'(mem_fault), 64'd0);
    chk("ld_stall_cycles", 64'(stall_cnt), 64'd5);
    cyc();
    chk("ld_back_idle", 64'(dut.state_q), 64'(IDLE));

    // Lane extraction and extension
    load_txn(F3_B, 64'h2005, 64'h0000_80FF_0000_0000);
    chk("lb_addr", 64'(dmem_addr), 64'h2000);
    chk("lb_data", ReadData, 64'hFFFF_FFFF_FFFF_FF80);
    load_txn(F3_BU, 64'h2005, 64'h0000_80FF_0000_0000);
    chk("lbu_data", ReadData, 64'h0000_0000_0000_0080);
    load_txn(F3_H, 64'h2006, 64'h8001_0000_0000_0000);
    chk("lh_data", ReadData, 64'hFFFF_FFFF_FFFF_8001);
    load_txn(F3_WU, 64'h2004, 64'h8765_4321_0000_0000);
    chk("lwu_data", ReadData, 64'h0000_0000_8765_4321);
    load_txn(F3_W, 64'h2004, 64'h8765_4321_0000_0000);
    chk("lw_data", ReadData, 64'hFFFF_FFFF_8765_4321);

    // sw 0x3004: DONE directly after grant
    cyc();
    EXM_MemWrite = 1'b1; EXM_funct3 = F3_W; EXM_ALUResult = 64'h3004;
    EXM_WriteData = 64'hDEADBEEF;
    #1;
    chk("sw_idle_stall", 64'(mem_stall), 64'd1);
    cyc(); dmem_gnt = 1'b1; #1;
    chk("sw_req", 64'(dmem_req), 64'd1);
    chk("sw_addr", 64'(dmem_addr), 64'h3000);
    chk("sw_be", 64'(dmem_be), 64'hF0);
    chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
    chk("sw_we", 64'(dmem_we), 64'd1);
    cyc(); dmem_gnt = 1'b0; EXM_MemWrite = 1'b0; #1;
    chk("sw_done_state", 64'(dut.state_q), 64'(DONE));
    chk("sw_done_stall", 64'(mem_stall), 64'd0);
    chk("sw_done_fault", 64'(mem_fault), 64'd0);
    cyc();

    // Illegal accesses: immediate fault, no bus activity, ReadData unchanged
    EXM_MemRead = 1'b1; EXM_funct3 = F3_W; EXM_ALUResult = 64'h4002;
    #1;
    chk("mis_fault", 64'(mem_fault), 64'd1);
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_stall", 64'(mem_stall), 64'd0);
    cyc();
    chk("mis_state", 64'(dut.state_q), 64'(IDLE));
    chk("mis_readdata", ReadData, 64'hFFFF_FFFF_8765_4321);
    EXM_MemWrite = 1'b1; EXM_funct3 = F3_D; EXM_ALUResult = 64'h4000;
    #1;
    chk("rw_fault", 64'(mem_fault), 64'd1);
    chk("rw_stall", 64'(mem_stall), 64'd0);
    EXM_MemRead = 1'b0; EXM_funct3 = F3_BU;
    #1;
    chk("sbu_fault", 64'(mem_fault), 64'd1);
    chk("sbu_stall", 64'(mem_stall), 64'd0);
    EXM_MemWrite = 1'b0;
    #1;
    chk("noop_fault", 64'(mem_fault), 64'd0);

    // Timeout: four WAIT cycles without rvalid
    cyc();
    EXM_MemRead = 1'b1; EXM_funct3 = F3_D; EXM_ALUResult = 64'h5000;
    cyc(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0;
    cyc(); cyc(); cyc(); #1;
    chk("to_wait4_state", 64'(dut.state_q), 64'(WAIT));
    chk("to_wait4_stall", 64'(mem_stall), 64'd1);
    cyc(); EXM_MemRead = 1'b0; #1;
    chk("to_done_state", 64'(dut.state_q), 64'(DONE));
    chk("to_fault", 64'(mem_fault), 64'd1);
    chk("to_readdata", ReadData, 64'd0);
    chk("to_stall", 64'(mem_stall), 64'd0);
    cyc(); #1;
    chk("to_fault_clr", 64'(mem_fault), 64'd0);

    // rvalid in the fourth WAIT cycle wins over the timeout
    EXM_MemRead = 1'b1; EXM_funct3 = F3_D; EXM_ALUResult = 64'h5008;
    cyc(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0;
    cyc(); cyc(); cyc();
    dmem_rvalid = 1'b1; dmem_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    cyc(); dmem_rvalid = 1'b0; EXM_MemRead = 1'b0; #1;
    chk("rv4_state", 64'(dut.state_q), 64'(DONE));
    chk("rv4_fault", 64'(mem_fault), 64'd0);
    chk("rv4_readdata", ReadData, 64'hA5A5_5A5A_0F0F_F0F0);
    cyc();

    // Reset in WAIT, then a late rvalid
    EXM_MemRead = 1'b1; EXM_funct3 = F3_D; EXM_ALUResult = 64'h6000;
    cyc(); dmem_gnt = 1'b1;
    cyc(); dmem_gnt = 1'b0; #1;
    chk("rw_wait_state", 64'(dut.state_q), 64'(WAIT));
    #2;
    reset = 1'b1; EXM_MemRead = 1'b0;
    #1;
    chk("rstw_state", 64'(dut.state_q), 64'(IDLE));
    chk("rstw_readdata", ReadData, 64'd0);
    chk("rstw_stall", 64'(mem_stall), 64'd0);
    cyc();
    reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h1234_5678_9ABC_DEF0;
    cyc(); dmem_rvalid = 1'b0; #1;
    chk("late_rv_state", 64'(dut.state_q), 64'(IDLE));
    chk("late_rv_readdata", ReadData, 64'd0);
    chk("late_rv_stall", 64'(mem_stall), 64'd0);
    cyc();
    chk("late_rv_no_done", 64'(dut.state_q), 64'(IDLE));
    chk("late_rv_fault", 64'(mem_fault), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit for the 64-bit five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts EX/MEM load/store controls into a request/grant/rvalid transaction on the data-memory bus.
- Aligns and extends load data into `ReadData` for MEM/WB.
- Stalls the pipeline while a transaction is outstanding and flags misaligned, illegal or timed-out accesses.

Parameters:
- XLEN, 64, datapath width; the only supported value.
- ADDR_W, 32, data-memory bus address width.
- TIMEOUT, 255, maximum cycles spent in WAIT before the access is aborted; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- EXM_MemRead  input  1  load in MEM stage.
- EXM_MemWrite  input  1  store in MEM stage.
- EXM_funct3  input  3  access size and signedness (RV64I encoding).
- EXM_ALUResult  input  64  effective byte address.
- EXM_WriteData  input  64  store data, right-justified.
- ReadData  output  64  aligned, extended load data to MEM/WB.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; bubbles MEM/WB.
- mem_fault  output  1  access rejected or aborted.
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  ADDR_W  doubleword-aligned address, EXM_ALUResult[ADDR_W-1:3] concatenated with 3'b000.
- dmem_be  output  8  byte enables.
- dmem_wdata  output  64  lane-shifted store data.
- dmem_gnt  input  1  request accepted.
- dmem_rvalid  input  1  read data valid.
- dmem_rdata  input  64  raw doubleword.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; timeout counter = 0.
  - ReadData = 0; dmem_req = 0; dmem_we = 0; dmem_be = 0; dmem_addr = 0; dmem_wdata = 0.
  - mem_stall = 0 and mem_fault = 0 while no operation is presented.
- "op" means EXM_MemRead | EXM_MemWrite.
- An op is illegal in any of these cases:
  - EXM_MemRead and EXM_MemWrite are both set.
  - funct3 = 111 on a load.
  - funct3[2] = 1 on a store.
  - The address is misaligned: h requires addr[0] = 0, w requires addr[1:0] = 0, d requires addr[2:0] = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, legal op present: capture address, we, be and wdata into registers; go to REQ.
  - IDLE, illegal op present: mem_fault = 1 combinationally; no bus activity; ReadData unchanged; stay in IDLE.
  - REQ: dmem_req = 1 with the captured fields held stable until dmem_gnt.
    - Grant on a store: go to DONE.
    - Grant on a load: go to WAIT.
  - WAIT: dmem_req = 0; counter increments each cycle.
    - dmem_rvalid: ReadData <= extended load data; go to DONE.
    - Counter reaches TIMEOUT: ReadData <= 0; set the fault flag; go to DONE.
    - rvalid in the same cycle as the timeout: rvalid wins and no fault is raised.
  - DONE: mem_stall = 0 for exactly one cycle; mem_fault = the latched flag. The next state is IDLE, clearing the counter and the flag.
- mem_stall = (IDLE and legal op) | REQ | WAIT. It is combinational, so the op is frozen in EX/MEM until DONE.
  - At the DONE clock edge EX/MEM advances. IDLE therefore never re-issues the same op.
- Load-to-ReadData latency: ReadData is valid in DONE, one cycle after the rvalid edge, and MEM/WB samples it there.
  - ReadData holds its value until the next rvalid, timeout or reset.
- Load extraction: the byte lane is selected by addr[2:0]. lb, lh and lw sign-extend; lbu, lhu and lwu zero-extend; ld passes through.
- Store lanes:
  - dmem_wdata = EXM_WriteData shifted left by 8*addr[2:0].
  - dmem_be: sb = 0x01 << off; sh = 0x03 << off; sw = 0x0F << off; sd = 0xFF.
- dmem_gnt and dmem_rvalid are ignored in IDLE and DONE. An rvalid that arrives in REQ is ignored.
- Asynchronous reset mid-transaction returns the FSM to IDLE at once.
  - A late rvalid arriving afterwards is ignored because the FSM is in IDLE.

Decomposition:
- Shared package `mem_pkg`:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - The state enum {IDLE, REQ, WAIT, DONE}.
  - The be-mask function.
- One combinational sub-module `load_align_ext` with inputs rdata, off[2:0] and funct3, and output ReadData_next.

Test Plan:
- ld at address 0x1000, gnt after 1 cycle, rvalid 2 cycles later with rdata 0x1122334455667788:
  - dmem_addr = 0x1000, be = 0xFF.
  - mem_stall high for 5 cycles.
  - ReadData = 0x1122334455667788 in DONE; fault = 0.
- lb at 0x2005 with rdata 0x0000_80FF_0000_0000: ReadData = 0xFFFF_FFFF_FFFF_FF80. Repeat with lbu: ReadData = 0x80.
- sw at 0x3004 with WriteData 0xDEADBEEF:
  - be = 0xF0, wdata = 0xDEADBEEF_00000000, dmem_we = 1.
  - DONE follows the grant; no WAIT state.
- lw at 0x4002: mem_fault = 1 the same cycle, dmem_req stays 0, mem_stall = 0. Also check MemRead = MemWrite = 1 gives the same fault response.
- Load with no rvalid and TIMEOUT = 4: 4 cycles in WAIT, then DONE with mem_fault = 1 and ReadData = 0. A second run with rvalid in the 4th WAIT cycle gives no fault.
- Assert reset in WAIT, then drive rvalid: ReadData = 0, FSM in IDLE, mem_stall = 0, and no DONE pulse.
